// File: rtl/me_lsu_pkg.sv
// me_lsu shared types: size/fault encodings, FSM states, default widths.
// Also holds the address-legality helper used by the LSU front end.
package me_lsu_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_INSTR_W    = 32;
  localparam int DEF_REG_IDX_W  = 5;
  localparam int DEF_DEST_SRC_W = 2;
  localparam int DEF_TIMEOUT    = 255;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10,
    MEM_SIZE_R = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_SIZE     = 2'b10,
    FAULT_TIMEOUT  = 2'b11
  } fault_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  function automatic fault_e addr_fault(
    input logic [1:0] size,
    input logic [1:0] a
  );
    fault_e f;
    f = FAULT_NONE;
    if (size == MEM_SIZE_R)
      f = FAULT_SIZE;
    else if (size == MEM_SIZE_H && a[0])
      f = FAULT_MISALIGN;
    else if (size == MEM_SIZE_W && a != 2'b00)
      f = FAULT_MISALIGN;
    return f;
  endfunction

endpackage

// File: rtl/me_load_align.sv
// Load data aligner: shifts the addressed lane down and extends it.
// Ports: rdata/off/size/uns in, data out (combinational).
module me_load_align
  import me_lsu_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic [WORD_W-1:0] rdata,
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [WORD_W-1:0] data
);

  logic [WORD_W-1:0] lane;

  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    data = rdata;
    unique case (1'b1)
      size == MEM_SIZE_B:
        data = {{(WORD_W-8){~uns & lane[7]}}, lane[7:0]};
      size == MEM_SIZE_H:
        data = {{(WORD_W-16){~uns & lane[15]}}, lane[15:0]};
      default:
        data = rdata;
    endcase
  end

endmodule

// File: rtl/me_lsu.sv
// Memory-access stage: issues req/gnt/rvalid transactions, aligns loads,
// registers the MEM/WB result, and stalls upstream while a request is live.
module me_lsu
  import me_lsu_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int REG_IDX_W  = DEF_REG_IDX_W,
  parameter int DEST_SRC_W = DEF_DEST_SRC_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic [WORD_W-1:0]     i_st_data,
  input  logic                  i_mem_en,
  input  logic                  i_mem_we,
  input  logic [1:0]            i_mem_size,
  input  logic                  i_mem_uns,
  output logic                  o_busy,
  output logic                  o_req,
  output logic                  o_we,
  output logic [ADDR_W-1:0]     o_addr,
  output logic [WORD_W-1:0]     o_wdata,
  output logic [3:0]            o_wmask,
  input  logic                  i_gnt,
  input  logic                  i_rvalid,
  input  logic [WORD_W-1:0]     i_rdata,
  output logic                  o_wb_valid,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [WORD_W-1:0]     o_wb_data,
  output logic                  o_fault,
  output logic [1:0]            o_fault_cause
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_e        state;
  logic [CNT_W-1:0]  cnt;
  fault_e            chk;
  logic              start;
  logic              tmo;
  logic [WORD_W-1:0] ld_data;
  logic              ev_wb;
  logic              ev_flt;
  fault_e            ev_cause;
  logic [WORD_W-1:0] ev_data;

  assign chk   = addr_fault(i_mem_size, i_alu_eval[1:0]);
  assign start = (state == ST_IDLE) & i_valid & i_mem_en
               & (chk == FAULT_NONE);
  // Last REQ/WAIT cycle before the counter would reach TIMEOUT.
  assign tmo   = (cnt == CNT_W'(TIMEOUT - 1));

  assign o_req  = (state == ST_REQ);
  assign o_busy = o_req | (state == ST_WAIT) | start;
  assign o_we   = o_req & i_mem_we;
  assign o_addr = {i_alu_eval[ADDR_W-1:2], 2'b00};

  always_comb begin
    o_wdata = i_st_data;
    o_wmask = 4'b1111;
    unique case (1'b1)
      i_mem_size == MEM_SIZE_B: begin
        o_wdata = {(WORD_W/8){i_st_data[7:0]}};
        o_wmask = 4'b0001 << i_alu_eval[1:0];
      end
      i_mem_size == MEM_SIZE_H: begin
        o_wdata = {(WORD_W/16){i_st_data[15:0]}};
        o_wmask = 4'b0011 << i_alu_eval[1:0];
      end
      default: begin
        o_wdata = i_st_data;
        o_wmask = 4'b1111;
      end
    endcase
  end

  me_load_align #(.WORD_W(WORD_W)) u_align (
    .rdata (i_rdata),
    .off   (i_alu_eval[1:0]),
    .size  (i_mem_size),
    .uns   (i_mem_uns),
    .data  (ld_data)
  );

  // Completion events; a real response wins over a same-cycle timeout.
  always_comb begin
    ev_wb    = 1'b0;
    ev_flt   = 1'b0;
    ev_cause = FAULT_NONE;
    ev_data  = i_alu_eval;
    unique case (state)
      ST_IDLE: begin
        if (i_valid & ~i_mem_en) begin
          ev_wb = 1'b1;
        end else if (i_valid & (chk != FAULT_NONE)) begin
          ev_flt   = 1'b1;
          ev_cause = chk;
        end
      end
      ST_REQ: begin
        if (i_gnt & i_mem_we) begin
          ev_wb = 1'b1;
        end else if (i_gnt & i_rvalid) begin
          ev_wb   = 1'b1;
          ev_data = ld_data;
        end else if (tmo) begin
          ev_flt   = 1'b1;
          ev_cause = FAULT_TIMEOUT;
        end
      end
      ST_WAIT: begin
        if (i_rvalid) begin
          ev_wb   = 1'b1;
          ev_data = ld_data;
        end else if (tmo) begin
          ev_flt   = 1'b1;
          ev_cause = FAULT_TIMEOUT;
        end
      end
      ST_DONE: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      o_wb_valid    <= 1'b0;
      o_pc          <= '0;
      o_instr       <= '0;
      o_dest_src    <= '0;
      o_dest_reg    <= '0;
      o_wb_data     <= '0;
      o_fault       <= 1'b0;
      o_fault_cause <= 2'b00;
    end else begin
      o_wb_valid    <= ev_wb;
      o_fault       <= ev_flt;
      o_fault_cause <= ev_cause;
      if (ev_wb | ev_flt) begin
        o_pc       <= i_pc;
        o_instr    <= i_instr;
        o_dest_src <= i_dest_src;
        o_dest_reg <= i_dest_reg;
      end
      if (ev_wb)
        o_wb_data <= ev_data;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_REQ;
            cnt   <= '0;
          end
        end
        ST_REQ: begin
          if (ev_wb | ev_flt) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (i_gnt)
              state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ev_wb | ev_flt)
            state <= ST_DONE;
          else
            cnt <= cnt + 1'b1;
        end
        ST_DONE:
          state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_lsu.sv
// Self-checking bench for me_lsu: directed table, random ops vs model,
// timeout and mid-transaction clear sequences.
module tb_me_lsu;
  import me_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        i_valid;
  logic [31:0] i_pc;
  logic [31:0] i_instr;
  logic [1:0]  i_dest_src;
  logic [4:0]  i_dest_reg;
  logic [31:0] i_alu_eval;
  logic [31:0] i_st_data;
  logic        i_mem_en;
  logic        i_mem_we;
  logic [1:0]  i_mem_size;
  logic        i_mem_uns;
  logic        o_busy;
  logic        o_req;
  logic        o_we;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [3:0]  o_wmask;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        o_wb_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic [1:0]  o_dest_src;
  logic [4:0]  o_dest_reg;
  logic [31:0] o_wb_data;
  logic        o_fault;
  logic [1:0]  o_fault_cause;

  always #5 clk = ~clk;

  me_lsu dut (
    .clk           (clk),
    .clr           (clr),
    .i_valid       (i_valid),
    .i_pc          (i_pc),
    .i_instr       (i_instr),
    .i_dest_src    (i_dest_src),
    .i_dest_reg    (i_dest_reg),
    .i_alu_eval    (i_alu_eval),
    .i_st_data     (i_st_data),
    .i_mem_en      (i_mem_en),
    .i_mem_we      (i_mem_we),
    .i_mem_size    (i_mem_size),
    .i_mem_uns     (i_mem_uns),
    .o_busy        (o_busy),
    .o_req         (o_req),
    .o_we          (o_we),
    .o_addr        (o_addr),
    .o_wdata       (o_wdata),
    .o_wmask       (o_wmask),
    .i_gnt         (i_gnt),
    .i_rvalid      (i_rvalid),
    .i_rdata       (i_rdata),
    .o_wb_valid    (o_wb_valid),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_dest_src    (o_dest_src),
    .o_dest_reg    (o_dest_reg),
    .o_wb_data     (o_wb_data),
    .o_fault       (o_fault),
    .o_fault_cause (o_fault_cause)
  );

  typedef struct {
    logic        mem_en;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] st;
    logic [31:0] rdata;
    int          gd;
    int          rd;
  } op_t;

  typedef struct {
    logic        wb;
    logic [31:0] data;
    logic        flt;
    logic [1:0]  cause;
    int          req;
    int          busy;
    logic        st;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic        done;
    logic        wb;
    logic [31:0] data;
    logic        flt;
    logic [1:0]  cause;
    int          req;
    int          busy;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [4:0]  dreg;
  } res_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle_in();
    i_valid    = 1'b0;
    i_pc       = '0;
    i_instr    = '0;
    i_dest_src = '0;
    i_dest_reg = '0;
    i_alu_eval = '0;
    i_st_data  = '0;
    i_mem_en   = 1'b0;
    i_mem_we   = 1'b0;
    i_mem_size = 2'b00;
    i_mem_uns  = 1'b0;
    i_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
  endtask

  // Behaves as the upstream stage plus a memory with programmable latency.
  task automatic do_op(input op_t op, input logic [31:0] pc,
                       input int bound, output res_t r);
    int  reqs;
    int  gcyc;
    logic busy;
    r.done = 0; r.wb = 0; r.data = 0; r.flt = 0; r.cause = 0;
    r.req = 0; r.busy = 0; r.mask = 0; r.wdata = 0; r.pc = 0; r.dreg = 0;
    reqs = 0;
    gcyc = -1;
    i_valid    = 1'b1;
    i_pc       = pc;
    i_instr    = ~pc;
    i_dest_src = pc[1:0];
    i_dest_reg = pc[6:2];
    i_mem_en   = op.mem_en;
    i_mem_we   = op.we;
    i_mem_size = op.size;
    i_mem_uns  = op.uns;
    i_alu_eval = op.addr;
    i_st_data  = op.st;
    i_rdata    = op.rdata;
    for (int c = 0; c < bound && !r.done; c++) begin
      i_gnt = o_req && op.gd >= 0 && reqs == op.gd;
      if (i_gnt) gcyc = c;
      i_rvalid = !op.we && op.rd >= 0 && gcyc >= 0 && (c - gcyc) == op.rd;
      @(negedge clk);
      busy = o_busy;
      if (o_busy) r.busy++;
      if (o_req) begin
        reqs++;
        r.mask  = o_wmask;
        r.wdata = o_wdata;
      end
      @(posedge clk);
      #1;
      i_gnt    = 1'b0;
      i_rvalid = 1'b0;
      if (!busy) i_valid = 1'b0;
      if (o_wb_valid || o_fault) begin
        r.done  = 1;
        r.wb    = o_wb_valid;
        r.data  = o_wb_data;
        r.flt   = o_fault;
        r.cause = o_fault_cause;
        r.pc    = o_pc;
        r.dreg  = o_dest_reg;
      end
    end
    r.req = reqs;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Reference: expected outcome from the architectural rules.
  task automatic model(input op_t op, output exp_t e);
    int unsigned a;
    logic [31:0] sh;
    logic [31:0] v;
    e.wb = 0; e.data = 0; e.flt = 0; e.cause = 0; e.req = 0;
    e.busy = 0; e.st = 0; e.mask = 0; e.wdata = 0;
    a = op.addr % 4;
    if (!op.mem_en) begin
      e.wb   = 1;
      e.data = op.addr;
    end else if (op.size == 2'd3) begin
      e.flt   = 1;
      e.cause = 2'd2;
    end else if ((op.size == 2'd1 && a % 2 != 0) ||
                 (op.size == 2'd2 && a != 0)) begin
      e.flt   = 1;
      e.cause = 2'd1;
    end else begin
      e.wb   = 1;
      e.req  = op.gd + 1;
      e.busy = 1 + e.req + (op.we ? 0 : op.rd);
      if (op.we) begin
        e.data = op.addr;
        e.st   = 1;
        if (op.size == 2'd0) begin
          e.mask  = 4'(1 << a);
          e.wdata = (op.st % 256) * 32'h0101_0101;
        end else if (op.size == 2'd1) begin
          e.mask  = 4'(3 << a);
          e.wdata = (op.st % 65536) * 32'h0001_0001;
        end else begin
          e.mask  = 4'hF;
          e.wdata = op.st;
        end
      end else begin
        sh = op.rdata >> (8 * a);
        if (op.size == 2'd0) begin
          v = sh % 256;
          if (!op.uns && v >= 128) v = v - 256;
        end else if (op.size == 2'd1) begin
          v = sh % 65536;
          if (!op.uns && v >= 32768) v = v - 65536;
        end else begin
          v = op.rdata;
        end
        e.data = v;
      end
    end
  endtask

  task automatic check_res(input string nm, input exp_t e, input res_t r,
                           input logic [31:0] pc);
    chk({nm, ".done"}, 32'(r.done), 32'd1);
    chk({nm, ".wb"}, 32'(r.wb), 32'(e.wb));
    chk({nm, ".flt"}, 32'(r.flt), 32'(e.flt));
    chk({nm, ".cause"}, 32'(r.cause), 32'(e.cause));
    chk({nm, ".req"}, r.req, e.req);
    chk({nm, ".busy"}, r.busy, e.busy);
    chk({nm, ".pc"}, r.pc, pc);
    chk({nm, ".dreg"}, 32'(r.dreg), 32'(pc[6:2]));
    if (e.wb) chk({nm, ".data"}, r.data, e.data);
    if (e.st) begin
      chk({nm, ".mask"}, 32'(r.mask), 32'(e.mask));
      chk({nm, ".wdata"}, r.wdata, e.wdata);
    end
  endtask

  vec_t vecs[12];
  op_t  op;
  exp_t e;
  res_t r;

  initial begin
    //          en we sz uns addr          st            rdata         gd rd
    vecs[0].op  = '{0, 0, 2, 0, 32'h1234,     0,            0,            0, 0};
    vecs[1].op  = '{1, 0, 0, 0, 32'h103,      0,            32'h80FFFF00, 0, 0};
    vecs[2].op  = '{1, 0, 0, 1, 32'h103,      0,            32'h80FFFF00, 0, 0};
    vecs[3].op  = '{1, 1, 1, 0, 32'h102,      32'hABCD,     0,            2, 0};
    vecs[4].op  = '{1, 0, 2, 0, 32'h101,      0,            0,            0, 0};
    vecs[5].op  = '{1, 0, 1, 0, 32'h103,      0,            0,            0, 0};
    vecs[6].op  = '{1, 0, 3, 0, 32'h100,      0,            0,            0, 0};
    vecs[7].op  = '{1, 0, 2, 0, 32'h200,      0,            32'hDEADBEEF, 1, 2};
    vecs[8].op  = '{1, 0, 1, 0, 32'h202,      0,            32'h80011234, 0, 1};
    vecs[9].op  = '{1, 1, 0, 0, 32'h101,      32'h123456A5, 0,            0, 0};
    vecs[10].op = '{1, 1, 2, 0, 32'h104,      32'hCAFEF00D, 0,            0, 0};
    vecs[11].op = '{1, 0, 1, 1, 32'h102,      0,            32'h80011234, 0, 0};
    //          wb data          flt cause req busy st mask  wdata
    vecs[0].e   = '{1, 32'h1234,     0, 0, 0, 0, 0, 4'h0, 0};
    vecs[1].e   = '{1, 32'hFFFFFF80, 0, 0, 1, 2, 0, 4'h0, 0};
    vecs[2].e   = '{1, 32'h80,       0, 0, 1, 2, 0, 4'h0, 0};
    vecs[3].e   = '{1, 32'h102,      0, 0, 3, 4, 1, 4'hC, 32'hABCDABCD};
    vecs[4].e   = '{0, 0,            1, 1, 0, 0, 0, 4'h0, 0};
    vecs[5].e   = '{0, 0,            1, 1, 0, 0, 0, 4'h0, 0};
    vecs[6].e   = '{0, 0,            1, 2, 0, 0, 0, 4'h0, 0};
    vecs[7].e   = '{1, 32'hDEADBEEF, 0, 0, 2, 5, 0, 4'h0, 0};
    vecs[8].e   = '{1, 32'hFFFF8001, 0, 0, 1, 3, 0, 4'h0, 0};
    vecs[9].e   = '{1, 32'h101,      0, 0, 1, 2, 1, 4'h2, 32'hA5A5A5A5};
    vecs[10].e  = '{1, 32'h104,      0, 0, 1, 2, 1, 4'hF, 32'hCAFEF00D};
    vecs[11].e  = '{1, 32'h8001,     0, 0, 1, 2, 0, 4'h0, 0};

    idle_in();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(o_busy), 0);
    chk("rst.req", 32'(o_req), 0);
    chk("rst.wb_valid", 32'(o_wb_valid), 0);
    chk("rst.wb_data", o_wb_data, 0);
    chk("rst.fault", 32'(o_fault), 0);
    chk("rst.cause", 32'(o_fault_cause), 0);
    chk("rst.pc", o_pc, 0);
    clr = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, 32'h1000 + 32'(4 * i), 40, r);
      check_res($sformatf("vec%0d", i), vecs[i].e, r, 32'h1000 + 32'(4 * i));
    end

    for (int i = 0; i < 150; i++) begin
      op.mem_en = ($urandom_range(0, 3) != 0);
      op.we     = 1'($urandom_range(0, 1));
      op.size   = 2'($urandom_range(0, 3));
      op.uns    = 1'($urandom_range(0, 1));
      op.addr   = $urandom;
      op.st     = $urandom;
      op.rdata  = $urandom;
      op.gd     = int'($urandom_range(0, 3));
      op.rd     = int'($urandom_range(0, 3));
      model(op, e);
      do_op(op, 32'h8000 + 32'(4 * i), 40, r);
      check_res($sformatf("rnd%0d", i), e, r, 32'h8000 + 32'(4 * i));
    end

    // Grant but no read data: fault after TIMEOUT cycles in REQ+WAIT.
    op = '{1, 0, 2, 0, 32'h400, 0, 0, 0, -1};
    do_op(op, 32'h2000, 400, r);
    chk("tmo.done", 32'(r.done), 1);
    chk("tmo.flt", 32'(r.flt), 1);
    chk("tmo.cause", 32'(r.cause), 3);
    chk("tmo.wb", 32'(r.wb), 0);
    chk("tmo.busy", r.busy, DEF_TIMEOUT + 1);
    chk("tmo.idle_busy", 32'(o_busy), 0);
    chk("tmo.idle_req", 32'(o_req), 0);
    op = '{0, 0, 0, 0, 32'h5A5A, 0, 0, 0, 0};
    do_op(op, 32'h2004, 40, r);
    chk("tmo.after_wb", 32'(r.wb), 1);
    chk("tmo.after_data", r.data, 32'h5A5A);

    // Clear while waiting for read data; late response must be dropped.
    i_valid    = 1'b1;
    i_pc       = 32'h3000;
    i_mem_en   = 1'b1;
    i_mem_we   = 1'b0;
    i_mem_size = 2'd2;
    i_alu_eval = 32'h600;
    @(posedge clk);
    #1;
    chk("clr.req_up", 32'(o_req), 1);
    i_gnt = 1'b1;
    @(posedge clk);
    #1;
    i_gnt = 1'b0;
    @(posedge clk);
    #1;
    chk("clr.wait_busy", 32'(o_busy), 1);
    chk("clr.wait_req", 32'(o_req), 0);
    #2;
    clr     = 1'b1;
    i_valid = 1'b0;
    #1;
    chk("clr.async_busy", 32'(o_busy), 0);
    chk("clr.async_req", 32'(o_req), 0);
    @(posedge clk);
    #1;
    clr      = 1'b0;
    i_rvalid = 1'b1;
    i_gnt    = 1'b1;
    i_rdata  = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("clr.late_req%0d", k), 32'(o_req), 0);
      chk($sformatf("clr.late_busy%0d", k), 32'(o_busy), 0);
      chk($sformatf("clr.late_wb%0d", k), 32'(o_wb_valid), 0);
    end
    idle_in();
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
